// File: rtl/wb_reg_slave.sv
// Wishbone classic register bank between the CPU bus and the tile controller.
// Optional macro WB_REG_SLAVE_ERR_EN adds p_wb_ERR_O for unmapped / empty-SEL status accesses.
module wb_reg_slave #(
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        p_clk,
  input  logic        p_reset,
  input  logic        p_wb_CYC_I,
  input  logic        p_wb_STB_I,
  input  logic        p_wb_WE_I,
  input  logic [3:0]  p_wb_SEL_I,
  input  logic [31:0] p_wb_ADR_I,
  input  logic [31:0] p_wb_DAT_I,
  output logic [31:0] p_wb_DAT_O,
  output logic        p_wb_ACK_O,
`ifdef WB_REG_SLAVE_ERR_EN
  output logic        p_wb_ERR_O,
`endif
  output logic [31:0] wb_reg_data,
  output logic [31:0] wb_reg_ctr,
  input  logic        p_ctrl_irq,
  output logic        p_irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic        commit;
  logic        req;
  logic        we_q, hit_q;
  logic [3:0]  sel_q;
  logic [1:0]  idx_q;
  logic [31:0] dat_q;
  logic        acc_we, acc_hit;
  logic [3:0]  acc_sel;
  logic [1:0]  acc_idx;
  logic [31:0] acc_dat;
  logic        irq_q, irq_q_d, done_evt;
  logic        done_pend;
  logic [15:0] done_count;
  logic [31:0] ctr_nxt;
  logic [31:0] rd_mux;
  logic        wr_hit, any_sel;
  logic        unused_adr;

  assign unused_adr = ^p_wb_ADR_I[1:0];
  assign req        = p_wb_CYC_I & p_wb_STB_I;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++)
      if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
    return res;
  endfunction

  // With no wait states the commit happens on the sampling edge, so live bus fields are used.
  always_comb begin
    if (state == ST_IDLE) begin
      acc_we  = p_wb_WE_I;
      acc_sel = p_wb_SEL_I;
      acc_idx = p_wb_ADR_I[3:2];
      acc_hit = (p_wb_ADR_I[31:4] == BASE_ADR[31:4]);
      acc_dat = p_wb_DAT_I;
    end else begin
      acc_we  = we_q;
      acc_sel = sel_q;
      acc_idx = idx_q;
      acc_hit = hit_q;
      acc_dat = dat_q;
    end
  end

  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      ST_IDLE:
        if (req) begin
          if (WAIT_CYCLES > 0) state_nxt = ST_WAIT;
          else begin
            state_nxt = ST_ACK;
            commit    = 1'b1;
          end
        end
      ST_WAIT:
        if (!req) state_nxt = ST_IDLE;
        else if (wait_cnt == 4'd0) begin
          state_nxt = ST_ACK;
          commit    = 1'b1;
        end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      hit_q    <= 1'b0;
      sel_q    <= 4'd0;
      idx_q    <= 2'd0;
      dat_q    <= 32'd0;
    end else if (state == ST_IDLE && req) begin
      wait_cnt <= WAIT_INIT;
      we_q     <= acc_we;
      hit_q    <= acc_hit;
      sel_q    <= acc_sel;
      idx_q    <= acc_idx;
      dat_q    <= acc_dat;
    end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  assign done_evt = irq_q & ~irq_q_d;
  assign wr_hit   = commit & acc_we & acc_hit;
  assign any_sel  = |acc_sel;

  // Done clears START first; a CPU write of byte 0 on the same edge then overrides it.
  always_comb begin
    ctr_nxt = wb_reg_ctr;
    if (done_evt) ctr_nxt[0] = 1'b0;
    if (wr_hit && acc_idx == 2'd1) ctr_nxt = merge_bytes(ctr_nxt, acc_dat, acc_sel);
  end

  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      irq_q       <= 1'b0;
      irq_q_d     <= 1'b0;
      wb_reg_data <= 32'd0;
      wb_reg_ctr  <= 32'd0;
      done_pend   <= 1'b0;
      done_count  <= 16'd0;
      p_irq       <= 1'b0;
    end else begin
      irq_q      <= p_ctrl_irq;
      irq_q_d    <= irq_q;
      wb_reg_ctr <= ctr_nxt;
      p_irq      <= done_pend & wb_reg_ctr[1];
      if (wr_hit && acc_idx == 2'd0)
        wb_reg_data <= merge_bytes(wb_reg_data, acc_dat, acc_sel);
      if (done_evt)
        done_pend <= 1'b1;
      else if (wr_hit && acc_idx == 2'd2 && any_sel && acc_dat[0])
        done_pend <= 1'b0;
      if (wr_hit && acc_idx == 2'd3 && any_sel)
        done_count <= {15'd0, done_evt};
      else if (done_evt)
        done_count <= done_count + 16'd1;
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    rd_mux = wb_reg_data;
      2'd1:    rd_mux = wb_reg_ctr;
      2'd2:    rd_mux = {30'd0, wb_reg_ctr[0], done_pend};
      default: rd_mux = {16'd0, done_count};
    endcase
    p_wb_DAT_O = (state == ST_ACK && !we_q && hit_q) ? rd_mux : 32'd0;
  end

`ifdef WB_REG_SLAVE_ERR_EN
  logic bad_q;
  assign bad_q      = !hit_q || (we_q && idx_q[1] && sel_q == 4'd0);
  assign p_wb_ACK_O = (state == ST_ACK) && !bad_q;
  assign p_wb_ERR_O = (state == ST_ACK) && bad_q;
`else
  assign p_wb_ACK_O = (state == ST_ACK);
`endif

endmodule
